// File: rtl/spi_sram_pkg.sv
// Shared serial-SRAM protocol definitions: command opcodes, mode encodings and responder states.
package spi_sram_pkg;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RDMR  = 8'h05;
    localparam logic [7:0] CMD_WRMR  = 8'h01;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_SEQ  = 2'b01;
    localparam logic [1:0] MODE_PAGE = 2'b10;
    localparam logic [7:0] MODE_RESET = 8'h40;

    localparam int PAGE_BYTES = 32;
    localparam int PAGE_BITS  = $clog2(PAGE_BYTES);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, RDATA, WDATA, MODE_RD, MODE_WR, IGNORE
    } spi_state_t;
endpackage

// File: rtl/spi_input_sync.sv
// Synchronizes the raw SPI pins into clk and produces edge pulses for sck and cs_n.
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic cs_n,
    input  logic mosi,
    output logic mosi_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall
);
    logic [SYNC_STAGES-1:0] sck_q, cs_q, mosi_q;
    logic sck_d, cs_d;

    // cs chain resets low: a select held low across reset must not look like a fresh falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
            sck_d  <= 1'b0;
            cs_d   <= 1'b0;
        end else begin
            sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sck_d  <= sck_q[SYNC_STAGES-1];
            cs_d   <= cs_q[SYNC_STAGES-1];
        end
    end

    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign sck_rise =  sck_q[SYNC_STAGES-1] & ~sck_d;
    assign sck_fall = ~sck_q[SYNC_STAGES-1] &  sck_d;
    assign cs_rise  =  cs_q[SYNC_STAGES-1]  & ~cs_d;
    assign cs_fall  = ~cs_q[SYNC_STAGES-1]  &  cs_d;
endmodule

// File: rtl/spi_sram_responder.sv
// Serial-SRAM SPI responder (mode 0) bridging READ/WRITE onto a byte-wide synchronous memory port.
// Define SPI_SRAM_RESPONDER_MODE_EN to add RDMR/WRMR and byte/page addressing modes.
module spi_sram_responder import spi_sram_pkg::*; #(
    parameter int ADDR_BITS   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sck,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic [7:0]           mem_rdata,
    output logic                 mem_wr,
    output logic [7:0]           mem_wdata
);
    spi_state_t state, state_nxt;
    logic       mosi_s, sck_rise, sck_fall, cs_rise, cs_fall;
    logic [2:0] bit_cnt;
    logic [1:0] addr_byte;
    logic [6:0] sh_in;
    logic [7:0] byte_in, out_sh, pf_buf;
    logic       byte_done, is_write, rd_d1, load_sh;
`ifdef SPI_SRAM_RESPONDER_MODE_EN
    logic [7:0] mode_reg;
`endif

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
        .mosi_s(mosi_s), .sck_rise(sck_rise), .sck_fall(sck_fall),
        .cs_rise(cs_rise), .cs_fall(cs_fall)
    );

    function automatic logic [ADDR_BITS-1:0] next_addr(input logic [ADDR_BITS-1:0] a);
`ifdef SPI_SRAM_RESPONDER_MODE_EN
        case (mode_reg[7:6])
            MODE_BYTE: next_addr = a;
            MODE_PAGE: next_addr = {a[ADDR_BITS-1:PAGE_BITS], a[PAGE_BITS-1:0] + PAGE_BITS'(1)};
            default:   next_addr = a + ADDR_BITS'(1);
        endcase
`else
        next_addr = a + ADDR_BITS'(1);
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        byte_in   = {sh_in, mosi_s};
        byte_done = sck_rise && (bit_cnt == 3'd7);
        state_nxt = state;
        if (cs_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (cs_fall) state_nxt = CMD;
                CMD: if (byte_done) begin
                    case (byte_in)
                        CMD_READ, CMD_WRITE: state_nxt = ADDR;
`ifdef SPI_SRAM_RESPONDER_MODE_EN
                        CMD_RDMR:            state_nxt = MODE_RD;
                        CMD_WRMR:            state_nxt = MODE_WR;
`endif
                        default:             state_nxt = IGNORE;
                    endcase
                end
                ADDR:    if (byte_done && addr_byte == 2'd2) state_nxt = is_write ? WDATA : RDATA;
                MODE_WR: if (byte_done) state_nxt = IGNORE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            addr_byte <= '0;
            sh_in     <= '0;
            out_sh    <= '0;
            pf_buf    <= '0;
            is_write  <= 1'b0;
            rd_d1     <= 1'b0;
            load_sh   <= 1'b0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
`ifdef SPI_SRAM_RESPONDER_MODE_EN
            mode_reg  <= MODE_RESET;
`endif
        end else begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            rd_d1  <= mem_rd;
            if (mem_wr) mem_addr <= next_addr(mem_addr);
            if (cs_rise || (state == IDLE && cs_fall)) begin
                bit_cnt   <= '0;
                addr_byte <= '0;
                sh_in     <= '0;
                out_sh    <= '0;
                miso      <= 1'b0;
                miso_oe   <= 1'b0;
                rd_d1     <= 1'b0;
                load_sh   <= 1'b0;
            end else begin
                if (sck_rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    sh_in   <= byte_in[6:0];
                end
                case (state)
                    CMD: if (byte_done) is_write <= (byte_in == CMD_WRITE);
                    ADDR: if (sck_rise) begin
                        mem_addr <= {mem_addr[ADDR_BITS-2:0], mosi_s};
                        if (bit_cnt == 3'd7) addr_byte <= addr_byte + 2'd1;
                        if (state_nxt == RDATA) begin
                            mem_rd  <= 1'b1;
                            load_sh <= 1'b1;
                        end
                    end
                    WDATA: if (byte_done) begin
                        mem_wr    <= 1'b1;
                        mem_wdata <= byte_in;
                    end
`ifdef SPI_SRAM_RESPONDER_MODE_EN
                    MODE_WR: if (byte_done) mode_reg <= byte_in;
`endif
                    default: ;
                endcase
                // First returned byte goes straight to the shifter; every later one is a prefetch.
                if (rd_d1) begin
                    if (load_sh) begin
                        out_sh   <= mem_rdata;
                        load_sh  <= 1'b0;
                        mem_addr <= next_addr(mem_addr);
                        mem_rd   <= 1'b1;
                    end else begin
                        pf_buf <= mem_rdata;
                    end
                end
                if (sck_fall && (state == RDATA || state == MODE_RD)) begin
                    miso_oe <= 1'b1;
                    if (bit_cnt != 3'd0 || (state == RDATA && !miso_oe)) begin
                        {miso, out_sh} <= {out_sh, 1'b0};
`ifdef SPI_SRAM_RESPONDER_MODE_EN
                    end else if (state == MODE_RD) begin
                        {miso, out_sh} <= {mode_reg, 1'b0};
`endif
                    end else begin
                        {miso, out_sh} <= {pf_buf, 1'b0};
                        mem_addr       <= next_addr(mem_addr);
                        mem_rd         <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_sram_responder.sv
// Self-checking bench: an SPI master drives table vectors and corner sequences against a memory model.
module tb_spi_sram_responder;
    localparam int AB   = 16;
    localparam int HALF = 8;

    logic          clk = 1'b0, rst_n = 1'b0, sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic          miso, miso_oe, mem_rd, mem_wr;
    logic [AB-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'h00, mem_wdata;

    always #5 clk = ~clk;

    spi_sram_responder #(.ADDR_BITS(AB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_wr(mem_wr), .mem_wdata(mem_wdata)
    );

    // Memory model: write on strobe, read data valid one clk after mem_rd.
    logic [7:0] mem [0:(1<<AB)-1];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] = mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    logic [AB+7:0] wr_obs [$];
    int rd_cnt = 0, wr_cnt = 0, oe_cnt = 0, both_cnt = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wr) begin
                wr_obs.push_back({mem_addr, mem_wdata});
                wr_cnt++;
            end
            if (mem_rd) rd_cnt++;
            if (miso_oe) oe_cnt++;
            if (mem_rd && mem_wr) both_cnt++;
        end
    end

    int checks = 0, errors = 0;
    logic [AB+7:0] wq [$];
    logic [7:0]    rq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx, output logic oe_all);
        rx = 8'h00;
        oe_all = 1'b1;
        for (int i = 7; i > 7 - nb; i--) begin
            mosi = tx[i];
            tick(HALF);
            rx[i]  = miso;
            oe_all = oe_all & miso_oe;
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic txn(input logic [7:0] cmd, input logic has_addr, input logic [23:0] a, input int nd,
                       input logic [7:0] d0, input logic [7:0] d1,
                       output logic [7:0] r0, output logic [7:0] r1, output logic oe);
        logic [7:0] rx;
        logic       o;
        cs_n = 1'b0;
        tick(HALF);
        spi_bits(cmd, 8, rx, o);
        if (has_addr) for (int i = 2; i >= 0; i--) spi_bits(a[i*8 +: 8], 8, rx, o);
        oe = 1'b1; r0 = 8'h00; r1 = 8'h00;
        if (nd > 0) begin spi_bits(d0, 8, r0, o); oe = oe & o; end
        if (nd > 1) begin spi_bits(d1, 8, r1, o); oe = oe & o; end
        tick(HALF);
        cs_n = 1'b1;
        tick(3*HALF);
    endtask

    task automatic check_writes(input string name);
        logic [AB+7:0] e;
        while (wq.size() > 0) begin
            e = wq.pop_front();
            if (wr_obs.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: no mem_wr seen, expected addr/data %h", name, e);
            end else begin
                chk(name, 32'(wr_obs.pop_front()), 32'(e));
            end
        end
        chk({name, "_extra_wr"}, wr_obs.size(), 0);
    endtask

    task automatic check_read(input string name, input logic [7:0] r0, input logic [7:0] r1, input logic oe);
        chk({name, "_byte0"}, 32'(r0), 32'(rq.pop_front()));
        chk({name, "_byte1"}, 32'(r1), 32'(rq.pop_front()));
        chk({name, "_oe_during"}, 32'(oe), 32'(1));
        chk({name, "_oe_after"}, 32'(miso_oe), 32'(0));
    endtask

    typedef struct {
        logic          is_rd;
        logic [23:0]   a;
        logic [7:0]    d0, d1;
        logic [AB-1:0] e0, e1;
    } vec_t;
    vec_t vt [6];

    initial begin
        logic [7:0] r0, r1, rx;
        logic       oe, o;
        int         rd0, wr0, oe0;

        vt[0] = '{1'b0, 24'h000010, 8'hA5, 8'h5A, 16'h0010, 16'h0011};
        vt[1] = '{1'b1, 24'h000010, 8'hA5, 8'h5A, 16'h0010, 16'h0011};
        vt[2] = '{1'b0, 24'h00FFFF, 8'h11, 8'h22, 16'hFFFF, 16'h0000};
        vt[3] = '{1'b0, 24'hAB1234, 8'hC3, 8'h3C, 16'h1234, 16'h1235};
        vt[4] = '{1'b1, 24'h00FFFF, 8'h96, 8'h69, 16'hFFFF, 16'h0000};
        vt[5] = '{1'b1, 24'h550100, 8'hDE, 8'hAD, 16'h0100, 16'h0101};

        tick(3);
        chk("rst_miso", 32'(miso), 0);
        chk("rst_miso_oe", 32'(miso_oe), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        rst_n = 1'b1;
        tick(5);

        for (int v = 0; v < 6; v++) begin
            if (vt[v].is_rd) begin
                mem[vt[v].e0] = vt[v].d0;
                mem[vt[v].e1] = vt[v].d1;
                rq.push_back(vt[v].d0);
                rq.push_back(vt[v].d1);
                txn(8'h03, 1'b1, vt[v].a, 2, 8'h00, 8'h00, r0, r1, oe);
                check_read($sformatf("v%0d_read", v), r0, r1, oe);
            end else begin
                wq.push_back({vt[v].e0, vt[v].d0});
                wq.push_back({vt[v].e1, vt[v].d1});
                txn(8'h02, 1'b1, vt[v].a, 2, vt[v].d0, vt[v].d1, r0, r1, oe);
                check_writes($sformatf("v%0d_write", v));
            end
        end

        // WRITE aborted after 5 data bits: no write, then a read decodes cleanly.
        wr0 = wr_cnt;
        cs_n = 1'b0;
        tick(HALF);
        spi_bits(8'h02, 8, rx, o);
        spi_bits(8'h00, 8, rx, o);
        spi_bits(8'h00, 8, rx, o);
        spi_bits(8'h40, 8, rx, o);
        spi_bits(8'hFF, 5, rx, o);
        tick(HALF);
        cs_n = 1'b1;
        tick(3*HALF);
        chk("abort_wr_cnt", wr_cnt - wr0, 0);
        check_writes("abort");
        mem[16'h0040] = 8'h77;
        mem[16'h0041] = 8'h88;
        rq.push_back(8'h77);
        rq.push_back(8'h88);
        txn(8'h03, 1'b1, 24'h000040, 2, 8'h00, 8'h00, r0, r1, oe);
        check_read("after_abort", r0, r1, oe);

        // Unknown command followed by 32 clocks stays silent.
        rd0 = rd_cnt; wr0 = wr_cnt; oe0 = oe_cnt;
        txn(8'hFF, 1'b1, 24'h000010, 1, 8'hA5, 8'h00, r0, r1, oe);
        chk("ignore_rd", rd_cnt - rd0, 0);
        chk("ignore_wr", wr_cnt - wr0, 0);
        chk("ignore_oe", oe_cnt - oe0, 0);

        // Reset mid-read with cs_n held low: bus ignored until a new select.
        rd0 = rd_cnt; oe0 = oe_cnt;
        cs_n = 1'b0;
        tick(HALF);
        spi_bits(8'h03, 8, rx, o);
        spi_bits(8'h00, 8, rx, o);
        spi_bits(8'h00, 8, rx, o);
        rst_n = 1'b0;
        tick(4);
        chk("midrst_oe", 32'(miso_oe), 0);
        rst_n = 1'b1;
        tick(4);
        spi_bits(8'h10, 8, rx, o);
        spi_bits(8'h00, 8, rx, o);
        spi_bits(8'h00, 8, rx, o);
        tick(HALF);
        cs_n = 1'b1;
        tick(3*HALF);
        chk("midrst_rd", rd_cnt - rd0, 0);
        chk("midrst_oe_cnt", oe_cnt - oe0, 0);
        rq.push_back(8'h77);
        rq.push_back(8'h88);
        txn(8'h03, 1'b1, 24'h000040, 2, 8'h00, 8'h00, r0, r1, oe);
        check_read("after_midrst", r0, r1, oe);

`ifdef SPI_SRAM_RESPONDER_MODE_EN
        rq.push_back(8'h40);
        rq.push_back(8'h40);
        txn(8'h05, 1'b0, 24'h0, 2, 8'h00, 8'h00, r0, r1, oe);
        check_read("rdmr_default", r0, r1, oe);
        txn(8'h01, 1'b0, 24'h0, 2, 8'h80, 8'h00, r0, r1, oe);
        check_writes("wrmr");
        wq.push_back({16'h001F, 8'h31});
        wq.push_back({16'h0000, 8'h32});
        txn(8'h02, 1'b1, 24'h00001F, 2, 8'h31, 8'h32, r0, r1, oe);
        check_writes("page_write");
        rq.push_back(8'h80);
        rq.push_back(8'h80);
        txn(8'h05, 1'b0, 24'h0, 2, 8'h00, 8'h00, r0, r1, oe);
        check_read("rdmr_page", r0, r1, oe);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        rq.push_back(8'h40);
        rq.push_back(8'h40);
        txn(8'h05, 1'b0, 24'h0, 2, 8'h00, 8'h00, r0, r1, oe);
        check_read("rdmr_after_rst", r0, r1, oe);
`else
        // Without mode support, RDMR is an unknown command.
        oe0 = oe_cnt; rd0 = rd_cnt;
        txn(8'h05, 1'b0, 24'h0, 2, 8'h00, 8'h00, r0, r1, oe);
        chk("rdmr_ignored_oe", oe_cnt - oe0, 0);
        chk("rdmr_ignored_rd", rd_cnt - rd0, 0);
`endif

        chk("rd_wr_overlap", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
